// File: rtl/char_pkg.sv
// Shared encodings for the character action bus, jump direction and facing.
package char_pkg;

  typedef enum logic [2:0] {
    ST_IDLE           = 3'd0,
    ST_LEFT           = 3'd1,
    ST_RIGHT          = 3'd2,
    ST_CHARGE         = 3'd3,
    ST_JUMP           = 3'd4,
    ST_COLLISION      = 3'd5,
    ST_FALL_TO_GROUND = 3'd6,
    ST_HOLD           = 3'd7
  } char_state_e;

  typedef enum logic [1:0] {
    JDIR_VERT  = 2'd0,
    JDIR_LEFT  = 2'd1,
    JDIR_RIGHT = 2'd2
  } jump_dir_e;

  typedef enum logic {
    FACE_RIGHT = 1'b0,
    FACE_LEFT  = 1'b1
  } face_dir_e;

  // Exactly one of left/right held selects a side; both or neither is vertical.
  function automatic jump_dir_e lr_to_jump_dir(input logic left, input logic right);
    if (left && !right) return JDIR_LEFT;
    if (right && !left) return JDIR_RIGHT;
    return JDIR_VERT;
  endfunction

endpackage

// File: rtl/character_tick_counter.sv
// Tick-enabled up counter with priority clear, saturation at MAX and a flag
// that is high when the next enabled tick reaches MAX.
module character_tick_counter #(
  parameter int unsigned MAX   = 32,
  parameter int unsigned WIDTH = $clog2(MAX + 1)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             tick_i,
  input  logic             clr_i,
  output logic [WIDTH-1:0] count_o,
  output logic             last_c_o
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (tick_i && (count_q != WIDTH'(MAX))) begin
      count_d = count_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o  = count_q;
  assign last_c_o = (count_q >= WIDTH'(MAX - 1));

endmodule

// File: rtl/character_action_controller.sv
// Player action sequencer: grounded dispatch, jump charge, airborne tracking,
// landing lockout, and the one-shot jump request to physics.
module character_action_controller
  import char_pkg::*;
#(
  parameter int          SIGNED_PHY_WIDTH = 17,
  parameter int          MAX_VEL_Y        = 10,
  parameter int unsigned MAX_CHARGE       = 32,
  parameter int unsigned CHARGE_WIDTH     = $clog2(MAX_CHARGE + 1),
  parameter int unsigned HOLD_TIME        = 64
) (
  input  logic                               sys_clk,
  input  logic                               sys_rst,
  input  logic                               character_clk,
  input  logic                               btn_left,
  input  logic                               btn_right,
  input  logic                               btn_jump,
  input  logic                               on_ground,
  input  logic                               collide,
  input  logic signed [SIGNED_PHY_WIDTH-1:0] vel_y,
  output logic [2:0]                         char_state,
  output logic [CHARGE_WIDTH-1:0]            charge_level,
  output logic                               jump_req,
  output logic [1:0]                         jump_dir,
  output logic                               face_dir
);

  localparam int unsigned HOLD_WIDTH = $clog2(HOLD_TIME + 1);
  localparam logic signed [SIGNED_PHY_WIDTH-1:0] HARD_LAND =
    SIGNED_PHY_WIDTH'(-(MAX_VEL_Y >>> 2));

  char_state_e                         state_q, state_d;
  face_dir_e                           face_q, face_d;
  jump_dir_e                           jdir_q, jdir_d;
  logic                                jreq_q, jreq_d;
  logic                                armed_q, armed_d;
  logic signed [SIGNED_PHY_WIDTH-1:0]  peak_q, peak_d;

  logic                    charge_clr, charge_last;
  logic                    hold_last;
  logic [HOLD_WIDTH-1:0]   hold_count;

  // Next-state and registered-output decisions, evaluated only on ticks.
  always_comb begin
    state_d    = state_q;
    face_d     = face_q;
    jdir_d     = jdir_q;
    jreq_d     = 1'b0;
    armed_d    = armed_q;
    peak_d     = peak_q;
    charge_clr = 1'b0;
    if (character_clk) begin
      if (!btn_jump) armed_d = 1'b1;
      unique case (state_q)
        ST_IDLE, ST_LEFT, ST_RIGHT: begin
          if (!on_ground) begin
            state_d = ST_JUMP;
          end else if (btn_jump && armed_q) begin
            state_d    = ST_CHARGE;
            charge_clr = 1'b1;
          end else if (btn_left ^ btn_right) begin
            state_d = btn_left ? ST_LEFT : ST_RIGHT;
            face_d  = btn_left ? FACE_LEFT : FACE_RIGHT;
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_CHARGE: begin
          jdir_d = lr_to_jump_dir(btn_left, btn_right);
          if (!on_ground) begin
            state_d = ST_JUMP;
          end else if (!btn_jump || charge_last) begin
            state_d = ST_JUMP;
            jreq_d  = 1'b1;
            // A saturated fire with the button still down must not re-charge on landing.
            if (btn_jump) armed_d = 1'b0;
          end
        end
        ST_JUMP: begin
          if (on_ground)    state_d = ST_FALL_TO_GROUND;
          else if (collide) state_d = ST_COLLISION;
        end
        ST_COLLISION: begin
          state_d = on_ground ? ST_FALL_TO_GROUND : ST_JUMP;
        end
        ST_FALL_TO_GROUND: begin
          state_d = (peak_q < HARD_LAND) ? ST_HOLD : ST_IDLE;
        end
        ST_HOLD: begin
          if (!on_ground)     state_d = ST_JUMP;
          else if (hold_last) state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
      if (state_q == ST_JUMP || state_q == ST_COLLISION) begin
        peak_d = (vel_y < peak_q) ? vel_y : peak_q;
      end else if (state_d == ST_JUMP) begin
        peak_d = '0;
      end
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q <= ST_IDLE;
      face_q  <= FACE_RIGHT;
      jdir_q  <= JDIR_VERT;
      jreq_q  <= 1'b0;
      armed_q <= 1'b1;
      peak_q  <= '0;
    end else begin
      state_q <= state_d;
      face_q  <= face_d;
      jdir_q  <= jdir_d;
      jreq_q  <= jreq_d;
      armed_q <= armed_d;
      peak_q  <= peak_d;
    end
  end

  character_tick_counter #(
    .MAX   (MAX_CHARGE),
    .WIDTH (CHARGE_WIDTH)
  ) u_charge_cnt (
    .clk_i    (sys_clk),
    .rst_i    (sys_rst),
    .tick_i   (character_clk && (state_q == ST_CHARGE)),
    .clr_i    (charge_clr),
    .count_o  (charge_level),
    .last_c_o (charge_last)
  );

  // Hold count runs 0..HOLD_TIME-1 and is cleared on any tick that leaves HOLD.
  character_tick_counter #(
    .MAX   (HOLD_TIME),
    .WIDTH (HOLD_WIDTH)
  ) u_hold_cnt (
    .clk_i    (sys_clk),
    .rst_i    (sys_rst),
    .tick_i   (character_clk && (state_q == ST_HOLD)),
    .clr_i    (character_clk && (state_d != ST_HOLD)),
    .count_o  (hold_count),
    .last_c_o (hold_last)
  );

  assign char_state = state_q;
  assign jump_req   = jreq_q;
  assign jump_dir   = jdir_q;
  assign face_dir   = face_q;

endmodule

// File: tb/tb_character_action_controller.sv
// Directed bench for character_action_controller with hand-computed expectations.
module tb_character_action_controller;

  logic               sys_clk = 1'b0;
  logic               sys_rst;
  logic               character_clk;
  logic               btn_left, btn_right, btn_jump;
  logic               on_ground, collide;
  logic signed [16:0] vel_y;
  logic [2:0]         char_state;
  logic [5:0]         charge_level;
  logic               jump_req;
  logic [1:0]         jump_dir;
  logic               face_dir;

  int checks = 0;
  int errors = 0;

  character_action_controller dut (
    .sys_clk       (sys_clk),
    .sys_rst       (sys_rst),
    .character_clk (character_clk),
    .btn_left      (btn_left),
    .btn_right     (btn_right),
    .btn_jump      (btn_jump),
    .on_ground     (on_ground),
    .collide       (collide),
    .vel_y         (vel_y),
    .char_state    (char_state),
    .charge_level  (charge_level),
    .jump_req      (jump_req),
    .jump_dir      (jump_dir),
    .face_dir      (face_dir)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    character_clk = 1'b1;
    @(posedge sys_clk);
    #1;
    character_clk = 1'b0;
  endtask

  task automatic idle();
    @(posedge sys_clk);
    #1;
  endtask

  initial begin
    int bad;
    sys_rst = 1'b1; character_clk = 1'b0;
    btn_left = 1'b0; btn_right = 1'b0; btn_jump = 1'b0;
    on_ground = 1'b1; collide = 1'b0; vel_y = '0;
    idle(); idle();
    check("rst_state", 32'(char_state), 0);
    check("rst_charge", 32'(charge_level), 0);
    check("rst_jreq", 32'(jump_req), 0);
    check("rst_jdir", 32'(jump_dir), 0);
    check("rst_face", 32'(face_dir), 0);
    sys_rst = 1'b0;

    // Walking and facing
    btn_left = 1'b1; tick();
    check("left_state", 32'(char_state), 1);
    check("left_face", 32'(face_dir), 1);
    btn_right = 1'b1; tick();
    check("both_state", 32'(char_state), 0);
    check("both_face", 32'(face_dir), 1);
    btn_left = 1'b0; tick();
    check("right_state", 32'(char_state), 2);
    check("right_face", 32'(face_dir), 0);
    btn_right = 1'b0; btn_left = 1'b1; idle();
    check("notick_hold", 32'(char_state), 2);
    btn_left = 1'b0; tick();
    check("none_state", 32'(char_state), 0);

    // Charge 5 ticks, release with right held
    btn_jump = 1'b1; tick();
    check("chg_enter", 32'(char_state), 3);
    check("chg_clear", 32'(charge_level), 0);
    repeat (4) tick();
    check("chg_4", 32'(charge_level), 4);
    check("chg_4_noreq", 32'(jump_req), 0);
    btn_jump = 1'b0; btn_right = 1'b1; tick();
    check("rel_state", 32'(char_state), 4);
    check("rel_charge", 32'(charge_level), 5);
    check("rel_jreq", 32'(jump_req), 1);
    check("rel_jdir", 32'(jump_dir), 2);
    btn_right = 1'b0; on_ground = 1'b0; idle();
    check("rel_pulse_end", 32'(jump_req), 0);
    tick();
    check("air_state", 32'(char_state), 4);
    on_ground = 1'b1; tick();
    check("land_soft", 32'(char_state), 6);
    tick();
    check("land_idle", 32'(char_state), 0);
    check("land_charge_held", 32'(charge_level), 5);

    // Walk-off with peak exactly at threshold -2: soft landing
    on_ground = 1'b0; tick();
    check("walkoff_state", 32'(char_state), 4);
    check("walkoff_noreq", 32'(jump_req), 0);
    vel_y = -17'sd2; tick();
    on_ground = 1'b1; vel_y = '0; tick();
    check("thr_fall", 32'(char_state), 6);
    tick();
    check("thr_idle", 32'(char_state), 0);

    // Saturating charge with button held
    btn_jump = 1'b1; tick();
    check("sat_enter", 32'(char_state), 3);
    repeat (31) tick();
    check("sat_31", 32'(charge_level), 31);
    check("sat_31_state", 32'(char_state), 3);
    tick();
    check("sat_state", 32'(char_state), 4);
    check("sat_charge", 32'(charge_level), 32);
    check("sat_jreq", 32'(jump_req), 1);
    check("sat_jdir", 32'(jump_dir), 0);
    idle();
    check("sat_pulse_end", 32'(jump_req), 0);
    tick();
    check("sat_fall", 32'(char_state), 6);
    tick(); tick(); tick();
    check("sat_no_rearm", 32'(char_state), 0);
    check("sat_level_held", 32'(charge_level), 32);
    btn_jump = 1'b0; tick();
    btn_jump = 1'b1; tick();
    check("rearm_state", 32'(char_state), 3);
    check("rearm_clear", 32'(charge_level), 0);
    btn_jump = 1'b0; btn_left = 1'b1; tick();
    check("min_charge", 32'(charge_level), 1);
    check("min_jreq", 32'(jump_req), 1);
    check("min_jdir", 32'(jump_dir), 1);
    btn_left = 1'b0;

    // Collision then simultaneous collide + land
    on_ground = 1'b0; collide = 1'b1; tick();
    check("coll_state", 32'(char_state), 5);
    check("coll_noreq", 32'(jump_req), 0);
    collide = 1'b0; tick();
    check("coll_back", 32'(char_state), 4);
    collide = 1'b1; on_ground = 1'b1; tick();
    check("coll_land_prio", 32'(char_state), 6);
    collide = 1'b0; tick();
    check("coll_idle", 32'(char_state), 0);

    // Hard landing and 64-tick lockout with jump ignored
    on_ground = 1'b0; tick();
    vel_y = -17'sd5; tick();
    vel_y = -17'sd3; tick();
    on_ground = 1'b1; vel_y = '0; tick();
    check("hard_fall", 32'(char_state), 6);
    btn_jump = 1'b1; tick();
    check("hold_enter", 32'(char_state), 7);
    bad = 0;
    for (int i = 0; i < 63; i++) begin
      tick();
      if (char_state !== 3'd7) bad++;
    end
    check("hold_63_ticks", 32'(bad), 0);
    btn_jump = 1'b0; tick();
    check("hold_exit", 32'(char_state), 0);

    // Airborne abort from CHARGE: no request
    btn_jump = 1'b1; tick();
    check("abort_enter", 32'(char_state), 3);
    on_ground = 1'b0; tick();
    check("abort_state", 32'(char_state), 4);
    check("abort_noreq", 32'(jump_req), 0);
    btn_jump = 1'b0; on_ground = 1'b1; tick(); tick();
    check("abort_idle", 32'(char_state), 0);

    // Reset mid-charge at level 10
    btn_jump = 1'b1; tick();
    repeat (10) tick();
    check("rc_level", 32'(charge_level), 10);
    btn_jump = 1'b0; sys_rst = 1'b1; tick();
    check("rc_state", 32'(char_state), 0);
    check("rc_charge", 32'(charge_level), 0);
    check("rc_jreq", 32'(jump_req), 0);
    sys_rst = 1'b0; idle();
    check("rc_jreq_after", 32'(jump_req), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
